// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, synchronous ROM request/capture, 2-entry
// instruction queue toward decode, and branch-redirect flush.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic [1:0]            rom_size,
  input  logic [63:0]           rom_data,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  typedef struct packed {
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_AL = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  entry_t                head_q, head_d, tail_q, tail_d;
  logic [1:0]            count_q, count_d;

  logic                  pop, push, issue;
  logic [2:0]            occ;
  entry_t                ret;

  // Only the low word of the ROM bus and the aligned target bits matter.
  logic unused_bits;
  assign unused_bits = ^{rom_data[63:32], branch_target[1:0]};

  assign pop   = (count_q != 2'd0) & instr_ready;
  assign push  = inflight_q & ~branch_valid;
  // Slots still committed after this cycle: queued + returning - leaving.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = ~branch_valid & (occ < 3'd2);
  assign ret   = '{instr: rom_data[31:0], pc: inflight_pc_q};

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (branch_valid) begin
      pc_d    = {branch_target[ADDR_WIDTH-1:2], 2'b00};
      count_d = 2'd0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + ADDR_WIDTH'(4);
      end
      // Head slot is the output register; it only changes when a new head exists.
      case ({push, pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = ret;
          end else begin
            head_d = ret;
          end
        end
        2'b01: begin
          count_d = count_q - 2'd1;
          if (count_q == 2'd2) head_d = tail_q;
        end
        2'b10: begin
          count_d = count_q + 2'd1;
          if (count_q == 2'd0) head_d = ret;
          else                 tail_d = ret;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC_AL;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= 2'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  assign rom_address = pc_q;
  assign rom_size    = 2'b10;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = head_q.instr;
  assign instr_pc    = head_q.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: two instances (RESET_PC 0 and 0xF8)
// each fed by a synchronous ROM model with word[i] = 0x1000_0000 + i.
module tb_instruction_fetch;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [7:0]  m_rom_address, w_rom_address;
  logic [1:0]  m_rom_size, w_rom_size;
  logic [63:0] m_rom_data, w_rom_data;
  logic        m_branch_valid, w_branch_valid;
  logic [7:0]  m_branch_target, w_branch_target;
  logic        m_valid, w_valid, m_ready, w_ready;
  logic [31:0] m_instr, w_instr;
  logic [7:0]  m_instr_pc, w_instr_pc;

  instruction_fetch #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clock(clock), .reset_n(reset_n),
    .rom_address(m_rom_address), .rom_size(m_rom_size), .rom_data(m_rom_data),
    .branch_valid(m_branch_valid), .branch_target(m_branch_target),
    .instr_valid(m_valid), .instr_ready(m_ready),
    .instr(m_instr), .instr_pc(m_instr_pc));

  instruction_fetch #(.ADDR_WIDTH(8), .RESET_PC(8'hF8)) dut_w (
    .clock(clock), .reset_n(reset_n),
    .rom_address(w_rom_address), .rom_size(w_rom_size), .rom_data(w_rom_data),
    .branch_valid(w_branch_valid), .branch_target(w_branch_target),
    .instr_valid(w_valid), .instr_ready(w_ready),
    .instr(w_instr), .instr_pc(w_instr_pc));

  // Synchronous ROM; upper half carries junk the DUT must ignore.
  always @(posedge clock) begin
    m_rom_data <= {24'hA5A5A5, m_rom_address, 32'h1000_0000 + 32'(m_rom_address >> 2)};
    w_rom_data <= {24'h5A5A5A, w_rom_address, 32'h1000_0000 + 32'(w_rom_address >> 2)};
  end

  typedef struct {
    logic [31:0] ins;
    logic [7:0]  pc;
  } exp_t;

  exp_t m_q[$];
  exp_t w_q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_hs  = 0;
  int   w_hs  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_stream(input bit wrap, input logic [7:0] start);
    exp_t e;
    for (int i = 0; i < 80; i++) begin
      e.pc  = start + 8'(4 * i);
      e.ins = 32'h1000_0000 + 32'(e.pc >> 2);
      if (wrap) w_q.push_back(e);
      else      m_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (m_valid && m_ready) begin
        m_hs++;
        if (m_q.size() == 0) chk("m_sb_empty", 64'd0, 64'd1);
        else begin
          e = m_q.pop_front();
          chk("m_pc", 64'(m_instr_pc), 64'(e.pc));
          chk("m_instr", 64'(m_instr), 64'(e.ins));
        end
      end
      // A pop in the branch cycle is compared above, before the flush.
      if (m_branch_valid) begin
        m_q.delete();
        push_stream(1'b0, {m_branch_target[7:2], 2'b00});
      end
      if (w_valid && w_ready) begin
        w_hs++;
        if (w_q.size() == 0) chk("w_sb_empty", 64'd0, 64'd1);
        else begin
          e = w_q.pop_front();
          chk("w_pc", 64'(w_instr_pc), 64'(e.pc));
          chk("w_instr", 64'(w_instr), 64'(e.ins));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    m_ready = 1'b0; m_branch_valid = 1'b0; m_branch_target = 8'h00;
    w_ready = 1'b1; w_branch_valid = 1'b0; w_branch_target = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_instr", 64'(m_instr), 64'd0);
    chk("rst_instr_pc", 64'(m_instr_pc), 64'd0);
    chk("rst_addr", 64'(m_rom_address), 64'h00);
    chk("rst_size", 64'(m_rom_size), 64'd2);
    chk("rst_w_addr", 64'(w_rom_address), 64'hF8);
    chk("rst_w_valid", 64'(w_valid), 64'd0);

    push_stream(1'b0, 8'h00);
    push_stream(1'b1, 8'hF8);
    reset_n = 1'b1; m_ready = 1'b1;            // cycle 0
    tick();                                    // cycle 1
    chk("c1_valid", 64'(m_valid), 64'd0);
    tick();                                    // cycle 2
    chk("c2_valid", 64'(m_valid), 64'd1);
    chk("c2_pc", 64'(m_instr_pc), 64'h00);
    chk("c2_instr", 64'(m_instr), 64'h1000_0000);
    chk("c2_w_pc", 64'(w_instr_pc), 64'hF8);

    tick();                                    // cycle 3: backpressure starts
    m_ready = 1'b0;
    chk("bp3_pc", 64'(m_instr_pc), 64'h04);
    for (int k = 4; k <= 7; k++) begin
      tick();
      chk("bp_valid", 64'(m_valid), 64'd1);
      chk("bp_addr", 64'(m_rom_address), 64'h0C);
      chk("bp_pc", 64'(m_instr_pc), 64'h04);
      chk("bp_instr", 64'(m_instr), 64'h1000_0001);
    end
    tick();
    m_ready = 1'b1;
    repeat (6) tick();

    m_ready = 1'b0;                            // fill FIFO, then branch
    repeat (3) tick();
    chk("full_valid", 64'(m_valid), 64'd1);
    m_branch_valid = 1'b1; m_branch_target = 8'h40;
    tick();                                    // B+1
    m_branch_valid = 1'b0;
    chk("br1_valid", 64'(m_valid), 64'd0);
    chk("br1_addr", 64'(m_rom_address), 64'h40);
    m_ready = 1'b1;
    tick();                                    // B+2
    chk("br2_valid", 64'(m_valid), 64'd0);
    tick();                                    // B+3
    chk("br3_valid", 64'(m_valid), 64'd1);
    chk("br3_pc", 64'(m_instr_pc), 64'h40);
    chk("br3_instr", 64'(m_instr), 64'h1000_0010);
    repeat (5) tick();

    m_branch_valid = 1'b1; m_branch_target = 8'h43;
    tick();
    m_branch_valid = 1'b0;
    chk("mis_addr", 64'(m_rom_address), 64'h40);
    repeat (2) tick();
    chk("mis_valid", 64'(m_valid), 64'd1);
    chk("mis_pc", 64'(m_instr_pc), 64'h40);
    repeat (6) tick();

    m_ready = 1'b0;                            // FIFO holds 2, then async reset
    repeat (3) tick();
    chk("prerst_valid", 64'(m_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(m_valid), 64'd0);
    chk("mrst_addr", 64'(m_rom_address), 64'h00);
    chk("mrst_instr", 64'(m_instr), 64'd0);
    chk("mrst_w_addr", 64'(w_rom_address), 64'hF8);
    m_q.delete();
    w_q.delete();
    push_stream(1'b0, 8'h00);
    push_stream(1'b1, 8'hF8);
    repeat (2) tick();
    reset_n = 1'b1; m_ready = 1'b1;            // cycle 0
    tick();
    chk("rel1_valid", 64'(m_valid), 64'd0);
    tick();
    chk("rel2_valid", 64'(m_valid), 64'd1);
    chk("rel2_pc", 64'(m_instr_pc), 64'h00);
    chk("rel2_instr", 64'(m_instr), 64'h1000_0000);
    repeat (10) tick();

    chk("m_hs_seen", 64'(m_hs > 20), 64'd1);
    chk("w_hs_seen", 64'(w_hs > 20), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage sitting directly upstream of the 64-bit instruction ROM. It holds the program counter, drives the ROM address and access size, and captures the returned word. It buffers fetched 32-bit instructions in a 2-entry queue and presents them to decode over a valid/ready handshake. Branch redirects from execute flush all queued and in-flight fetches.

## Interface
- ADDR_WIDTH, 8, byte-address width of PC and ROM address
- RESET_PC, 0, PC loaded on reset (low 2 bits forced to 0)

- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rom_address  out  ADDR_WIDTH  byte address to ROM, equals PC register
- rom_size  out  2  access size to ROM, constant 2'b10 (32-bit)
- rom_data  in  64  ROM read data; instruction in bits [31:0]
- branch_valid  in  1  redirect request, one-cycle pulse
- branch_target  in  ADDR_WIDTH  redirect byte address
- instr_valid  out  1  instr/instr_pc hold a valid instruction
- instr_ready  in  1  decode accepts instruction this cycle
- instr  out  32  fetched instruction
- instr_pc  out  ADDR_WIDTH  byte address of instr

## Operation
- ROM is synchronous: address sampled on edge N, data valid during the cycle after edge N, captured on edge N+1.
- State: pc, inflight (1 bit, request issued last cycle), inflight_pc, 2-entry FIFO of {instr, pc}, fifo_count (0..2).
- pop = instr_valid & instr_ready.
- Issue condition: !branch_valid and (fifo_count + inflight - pop) < 2. On issue: inflight <= 1, inflight_pc <= pc, pc <= pc + 4. Otherwise inflight <= 0 and pc holds (ROM keeps reading the same address; data ignored).
- Return: if inflight and !branch_valid, push {rom_data[31:0], inflight_pc} into FIFO. Push and pop may occur in the same cycle; the FIFO never overflows given the issue rule.
- Output: instr_valid = (fifo_count != 0); instr/instr_pc show the FIFO head, registered, never combinational from rom_data.
- Branch (branch_valid=1): pc <= {branch_target[ADDR_WIDTH-1:2], 2'b00}; FIFO cleared; inflight <= 0 (the returning word is discarded); no issue this cycle. A pop in the branch cycle still counts as accepted by decode. Fetch resumes at the target on the next cycle.
- PC arithmetic is modulo 2^ADDR_WIDTH: pc 0xFC + 4 -> 0x00, with no flag.
- FIFO empty: instr_valid=0 and instr/instr_pc hold their last value. FIFO full: no issue.

## Timing
- Reset (async assert): pc=RESET_PC, rom_address=RESET_PC, rom_size=2'b10, inflight=0, fifo_count=0, instr_valid=0, instr=0, instr_pc=0.
- Cycle 0 (first cycle with reset_n high): issue RESET_PC. Cycle 1: data returned and pushed. Cycle 2: instr_valid=1.
- Issue-to-valid latency is 2 cycles. With instr_ready held high, throughput is 1 instruction per cycle after the first.
- Branch in cycle B: instr_valid=0 in B+1 (fetch of target issued in B+1). First target instruction is valid in B+3.
- Reset asserted mid-operation: all state returns to reset values immediately. Fetch restarts at RESET_PC on release.
- instr/instr_pc are stable while instr_valid=1 and instr_ready=0.

## Test plan
- ROM preloaded with word[i] = 0x1000_0000+i, instr_ready=1 after reset: instr_valid rises in cycle 2; instructions 0x10000000, 0x10000001, ... appear with instr_pc 0x00, 0x04, ... every cycle.
- Backpressure: instr_ready=0 for 5 cycles from cycle 3: FIFO fills to 2, rom_address stalls, instr holds. On release, the sequence continues with no loss or duplication.
- Branch_valid pulse with branch_target=0x40 while FIFO is full: instr_valid=0 the next cycle. The next delivered instruction has instr_pc=0x40, then 0x44. No pre-branch instruction is delivered after the branch.
- Misaligned target 0x43: fetch starts at 0x40.
- Wrap: RESET_PC=0xF8: instr_pc sequence is 0xF8, 0xFC, 0x00, 0x04.
- Reset_n pulsed low mid-stream with the FIFO holding 2 entries: instr_valid=0 immediately and rom_address=RESET_PC. After release, the first instruction delivered is from RESET_PC in cycle 2.
